// File: rtl/speed_alert_pkg.sv
// Shared types and default phase lengths for the speed alert blinker.
package speed_alert_pkg;

  // Alert level as driven on the 2-bit level output.
  typedef enum logic [1:0] {
    LVL_NORMAL = 2'd0,
    LVL_WARN   = 2'd1,
    LVL_CRIT   = 2'd2
  } level_e;

  // Blinker FSM states: one ON/OFF pair per alert level.
  typedef enum logic [2:0] {
    IDLE,
    WARN_ON,
    WARN_OFF,
    CRIT_ON,
    CRIT_OFF
  } state_e;

  // Default phase lengths in clk cycles (2.048 kHz clock).
  localparam int DEF_SLOW_ON  = 1024;
  localparam int DEF_SLOW_OFF = 2048;
  localparam int DEF_FAST_ON  = 256;
  localparam int DEF_FAST_OFF = 256;

  // True for the states in which the lamp is lit.
  function automatic logic is_on_state(input state_e s);
    return (s == WARN_ON) || (s == CRIT_ON);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter for the blinker: counts up from 0, clears on request and
// flags the last cycle of the current phase (count == last_i).
module phase_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] last_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Counter register; the FSM clears it on every phase change, so it never
  // counts past last_i and cannot wrap.
  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = (cnt_q == last_i);

endmodule

// File: rtl/speed_alert_blinker.sv
// Speed alert lamp driver: compares speed against warning/critical
// thresholds and blinks the lamp slowly (WARN) or fast (CRIT).
// Optional feature: define ALERT_HYST_EN to add an exit hysteresis band of
// HYST km/h below each threshold.
module speed_alert_blinker
  import speed_alert_pkg::*;
#(
  parameter int SPEED_W  = 7,
  parameter int CNT_W    = 12,
  parameter int SLOW_ON  = DEF_SLOW_ON,
  parameter int SLOW_OFF = DEF_SLOW_OFF,
  parameter int FAST_ON  = DEF_FAST_ON,
  parameter int FAST_OFF = DEF_FAST_OFF,
  parameter int HYST     = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SPEED_W-1:0] kmh,
  input  logic [SPEED_W-1:0] thr_warn,
  input  logic [SPEED_W-1:0] thr_crit,
  input  logic               enable,
  output logic               blink,
  output logic [1:0]         level,
  output logic               level_chg
);

  localparam int PHASE_MAX = 1 << CNT_W;

  // Reject phase lengths the counter cannot represent, and a negative band.
  if (SLOW_ON  <= 0 || SLOW_ON  > PHASE_MAX ||
      SLOW_OFF <= 0 || SLOW_OFF > PHASE_MAX ||
      FAST_ON  <= 0 || FAST_ON  > PHASE_MAX ||
      FAST_OFF <= 0 || FAST_OFF > PHASE_MAX) begin : g_bad_phase
    $error("speed_alert_blinker: phase lengths must lie in 1..2**CNT_W");
  end
  if (HYST < 0) begin : g_bad_hyst
    $error("speed_alert_blinker: HYST must not be negative");
  end

  localparam logic [CNT_W-1:0] SLOW_ON_LAST  = CNT_W'(SLOW_ON  - 1);
  localparam logic [CNT_W-1:0] SLOW_OFF_LAST = CNT_W'(SLOW_OFF - 1);
  localparam logic [CNT_W-1:0] FAST_ON_LAST  = CNT_W'(FAST_ON  - 1);
  localparam logic [CNT_W-1:0] FAST_OFF_LAST = CNT_W'(FAST_OFF - 1);

  state_e           state_q, state_d;
  level_e           level_q, level_d;
  level_e           tgt_level;
  logic             blink_q, blink_d;
  logic             level_chg_q, level_chg_d;
  logic             crit_hold, warn_hold;
  logic             timer_clear, timer_expire;
  logic [CNT_W-1:0] phase_last;

`ifdef ALERT_HYST_EN
  localparam int               HYST_MAX = (1 << SPEED_W) - 1;
  localparam logic [SPEED_W-1:0] HYST_V = SPEED_W'((HYST > HYST_MAX) ? HYST_MAX : HYST);

  logic [SPEED_W-1:0] warn_exit, crit_exit;

  // Exit thresholds sit HYST below the entry thresholds, floored at 0.
  assign warn_exit = (thr_warn >= HYST_V) ? thr_warn - HYST_V : '0;
  assign crit_exit = (thr_crit >= HYST_V) ? thr_crit - HYST_V : '0;

  // A level already held is kept until speed falls through its exit point.
  assign crit_hold = (level_q == LVL_CRIT)   ? (kmh > crit_exit) : (kmh > thr_crit);
  assign warn_hold = (level_q != LVL_NORMAL) ? (kmh > warn_exit) : (kmh > thr_warn);
`else
  assign crit_hold = kmh > thr_crit;
  assign warn_hold = kmh > thr_warn;
`endif

  // Critical wins, so an inverted threshold pair still reports CRIT.
  assign tgt_level = crit_hold ? LVL_CRIT : (warn_hold ? LVL_WARN : LVL_NORMAL);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_phase_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (timer_clear),
    .last_i  (phase_last),
    .expire_o(timer_expire)
  );

  // Next state, level and timer control; level changes restart blinking.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    timer_clear = 1'b0;
    phase_last  = '0;

    case (state_q)
      WARN_ON:  phase_last = SLOW_ON_LAST;
      WARN_OFF: phase_last = SLOW_OFF_LAST;
      CRIT_ON:  phase_last = FAST_ON_LAST;
      CRIT_OFF: phase_last = FAST_OFF_LAST;
      default:  phase_last = '0;
    endcase

    if (!enable) begin
      state_d     = IDLE;
      level_d     = LVL_NORMAL;
      timer_clear = 1'b1;
    end else if (tgt_level != level_q) begin
      level_d     = tgt_level;
      timer_clear = 1'b1;
      case (tgt_level)
        LVL_WARN: state_d = WARN_ON;
        LVL_CRIT: state_d = CRIT_ON;
        default:  state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        WARN_ON:  if (timer_expire) begin state_d = WARN_OFF; timer_clear = 1'b1; end
        WARN_OFF: if (timer_expire) begin state_d = WARN_ON;  timer_clear = 1'b1; end
        CRIT_ON:  if (timer_expire) begin state_d = CRIT_OFF; timer_clear = 1'b1; end
        CRIT_OFF: if (timer_expire) begin state_d = CRIT_ON;  timer_clear = 1'b1; end
        default:  timer_clear = 1'b1;
      endcase
    end

    blink_d     = is_on_state(state_d);
    level_chg_d = (level_d != level_q);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      level_q     <= LVL_NORMAL;
      blink_q     <= 1'b0;
      level_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      blink_q     <= blink_d;
      level_chg_q <= level_chg_d;
    end
  end

  assign blink     = blink_q;
  assign level     = level_q;
  assign level_chg = level_chg_q;

endmodule

// File: tb/tb_speed_alert_blinker.sv
// Directed bench for speed_alert_blinker with default parameters.
// Define ALERT_HYST_EN for both bench and RTL to exercise the hysteresis build.
module tb_speed_alert_blinker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] kmh, thr_warn, thr_crit;
  logic       enable;
  logic       blink, level_chg;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int len, chg;

  always #5 clk = ~clk;

  speed_alert_blinker dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .kmh      (kmh),
    .thr_warn (thr_warn),
    .thr_crit (thr_crit),
    .enable   (enable),
    .blink    (blink),
    .level    (level),
    .level_chg(level_chg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Count consecutive cycles with blink == val (bounded) and level_chg pulses seen.
  task automatic measure(input logic val, output int n, output int pulses);
    n = 0;
    pulses = 0;
    while (blink === val && n < 5000) begin
      n++;
      if (level_chg === 1'b1) pulses++;
      tick(1);
    end
  endtask

  initial begin
    kmh = 7'd0; thr_warn = 7'd65; thr_crit = 7'd90; enable = 1'b1; reset_n = 1'b0;
    #3;
    check("reset_blink", blink, 0);
    check("reset_level", level, 0);
    check("reset_chg", level_chg, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(2);
    check("idle_level", level, 0);
    check("idle_blink", blink, 0);

    // Warning entry and slow blink cadence.
    kmh = 7'd66;
    tick(1);
    check("warn_level", level, 1);
    check("warn_blink", blink, 1);
    check("warn_chg", level_chg, 1);
    measure(1'b1, len, chg);
    check("warn_on_len", len, 1024);
    check("warn_on_chg", chg, 1);
    measure(1'b0, len, chg);
    check("warn_off_len", len, 2048);
    check("warn_off_chg", chg, 0);
    tick(499);
    check("warn_on2_blink", blink, 1);
    check("warn_on2_level", level, 1);

    // Escalation mid-ON restarts with the fast cadence.
    kmh = 7'd95;
    tick(1);
    check("crit_level", level, 2);
    check("crit_blink", blink, 1);
    check("crit_chg", level_chg, 1);
    measure(1'b1, len, chg);
    check("crit_on_len", len, 256);
    check("crit_on_chg", chg, 1);
    measure(1'b0, len, chg);
    check("crit_off_len", len, 256);
    measure(1'b1, len, chg);
    check("crit_on2_len", len, 256);
    check("crit_on2_chg", chg, 0);

    // Disable while critical.
    enable = 1'b0;
    tick(1);
    check("dis_level", level, 0);
    check("dis_blink", blink, 0);
    check("dis_chg", level_chg, 1);
    chg = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (level_chg === 1'b1) chg++;
    end
    check("dis_chg_once", chg, 0);
    enable = 1'b1;
    kmh = 7'd50;
    tick(1);
    check("reen_level", level, 0);
    check("reen_no_chg", level_chg, 0);

    // Inverted thresholds: critical is evaluated first.
    thr_crit = 7'd10;
    kmh = 7'd20;
    tick(1);
    check("inv_level", level, 2);
    check("inv_blink", blink, 1);
    check("inv_chg", level_chg, 1);

    // De-escalate to WARN, then reset mid-OFF.
    thr_crit = 7'd90;
    kmh = 7'd66;
    tick(1);
    check("deesc_level", level, 1);
    check("deesc_chg", level_chg, 1);
    measure(1'b1, len, chg);
    check("deesc_on_len", len, 1024);
    tick(100);
    check("mid_off_blink", blink, 0);
    check("mid_off_level", level, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_blink", blink, 0);
    check("async_rst_chg", level_chg, 0);
    @(posedge clk); #1;
    check("held_rst_level", level, 0);
    reset_n = 1'b1;
    tick(1);
    check("post_rst_level", level, 1);
    check("post_rst_blink", blink, 1);
    measure(1'b1, len, chg);
    check("post_rst_on_len", len, 1024);
    check("post_rst_on_chg", chg, 1);

    // Exit from WARN at and below the warning threshold.
`ifdef ALERT_HYST_EN
    kmh = 7'd65;
    tick(1);
    check("hyst_65_level", level, 1);
    kmh = 7'd63;
    tick(1);
    check("hyst_63_level", level, 1);
    check("hyst_63_chg", level_chg, 0);
    kmh = 7'd62;
    tick(1);
    check("hyst_62_level", level, 0);
    check("hyst_62_blink", blink, 0);
    check("hyst_62_chg", level_chg, 1);
`else
    kmh = 7'd65;
    tick(1);
    check("exit_65_level", level, 0);
    check("exit_65_blink", blink, 0);
    check("exit_65_chg", level_chg, 1);
`endif

    // Direct drop from CRIT to NORMAL.
    kmh = 7'd100;
    tick(1);
    check("drop_crit_level", level, 2);
    kmh = 7'd0;
    tick(1);
    check("drop_level", level, 0);
    check("drop_blink", blink, 0);
    check("drop_chg", level_chg, 1);
    tick(1);
    check("drop_chg_clear", level_chg, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_alert_blinker.md
SPEED_ALERT_BLINKER -- requirements
Module: speed_alert_blinker

Interface
REQ-001 The block SHALL have parameter SPEED_W, default 7, meaning the speed bus width in km/h.
REQ-002 The block SHALL have parameter CNT_W, default 12, meaning the phase counter width.
REQ-003 The block SHALL have parameters SLOW_ON/SLOW_OFF, default 1024/2048, meaning the warning-rate phase lengths in clk cycles (0.5 s/1.0 s at 2.048 kHz).
REQ-004 The block SHALL have parameters FAST_ON/FAST_OFF, default 256/256, meaning the critical-rate phase lengths in clk cycles.
REQ-005 The block SHALL have parameter HYST, default 3, meaning the hysteresis band in km/h.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-007 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port kmh, input, SPEED_W bits, the current speed.
REQ-009 The block SHALL have ports thr_warn and thr_crit, input, SPEED_W bits each, the runtime thresholds.
REQ-010 The block SHALL have port enable, input, 1 bit, the alert enable.
REQ-011 The block SHALL have port blink, output, 1 bit, the registered lamp drive.
REQ-012 The block SHALL have port level, output, 2 bits, encoded 0=NORMAL, 1=WARN, 2=CRIT.
REQ-013 The block SHALL have port level_chg, output, 1 bit, a one-cycle pulse on any level change.

Function
REQ-014 The FSM SHALL use the states IDLE, WARN_ON, WARN_OFF, CRIT_ON and CRIT_OFF.
REQ-015 Target level SHALL be computed as follows: CRIT if kmh > thr_crit, else WARN if kmh > thr_warn, else NORMAL; crit is evaluated first, so thr_crit < thr_warn still yields CRIT.
REQ-016 kmh sampled at edge N SHALL be reflected in state, level and blink after edge N (one-cycle latency).
REQ-017 Entering WARN or CRIT from any other level SHALL go to the *_ON state with counter=0 and blink=1.
REQ-018 In an ON state, blink SHALL stay 1 for exactly *_ON cycles, then go to *_OFF with counter=0 and blink=0 for exactly *_OFF cycles, then return to *_ON; the cycle repeats indefinitely.
REQ-019 A WARN<->CRIT change SHALL restart in the new level's ON state, counter=0, regardless of the current phase.
REQ-020 A drop to NORMAL SHALL go to IDLE with blink=0 and counter=0 on the next edge.
REQ-021 enable=0 SHALL force IDLE, level=0 and blink=0 on the next edge; level_chg SHALL pulse if level was nonzero.
REQ-022 level_chg SHALL be 1 for exactly one cycle after each edge where level changes; it SHALL never be asserted while level is unchanged.
REQ-023 The counter SHALL never wrap; an elaboration check SHALL fail if any phase length exceeds 2^CNT_W or equals 0.
REQ-024 Threshold changes SHALL take effect on the next edge, like any kmh change.

Reset
REQ-025 On reset_n=0, the block SHALL asynchronously set state=IDLE, counter=0, blink=0, level=0 and level_chg=0.
REQ-026 Reset asserted mid-phase SHALL abandon the phase; after release, the first blink SHALL start a fresh full ON phase.

Configuration
REQ-027 With ALERT_HYST_EN defined, WARN SHALL exit to NORMAL only when kmh <= thr_warn-HYST, and CRIT SHALL exit to WARN only when kmh <= thr_crit-HYST; subtraction SHALL saturate at 0, and entry thresholds SHALL be unchanged.
REQ-028 Without ALERT_HYST_EN, exits SHALL use the same thresholds as entry, HYST SHALL be ignored, and no hysteresis logic SHALL be synthesised.

Structure
REQ-029 Package speed_alert_pkg SHALL hold the level and state typedefs and the default phase-length constants.
REQ-030 Sub-module phase_timer SHALL provide a load/clear counter with an expire flag at length-1, instantiated once.

Verification
REQ-031 Bench SHALL cover: kmh=66, thr_warn=65, thr_crit=90 -> level=1 and blink=1 after 1 edge, high for 1024 cycles, low for 2048 cycles, repeating; level_chg pulses once.
REQ-032 Bench SHALL cover: from WARN at cycle 500 of ON, kmh=95 -> level=2 and blink restarts high for 256 cycles, then low 256.
REQ-033 Bench SHALL cover, with ALERT_HYST_EN: WARN then kmh=63 -> stays WARN; kmh=62 -> level=0, blink=0 next edge.
REQ-034 Bench SHALL cover, without ALERT_HYST_EN: WARN then kmh=65 -> level=0 next edge.
REQ-035 Bench SHALL cover: reset_n pulsed low mid-OFF phase -> outputs 0 immediately (asynchronous); after release with kmh=66 -> full 1024-cycle ON phase.
REQ-036 Bench SHALL cover: enable=0 during CRIT -> level=0, blink=0, single level_chg pulse; thr_crit=10, thr_warn=65, kmh=20 -> level=2.
